lr35902_dbg_ctl: RTL

Parametrised debug controller for the LR35902 core. It combines a UART command port, an N-entry enable-masked breakpoint unit and an instruction-granular single-step engine, all in one `cpu_clk` domain. It sits beside the CPU core: it samples `pc`/`sp`/`f`/`probe`, drives `halt`, and answers host commands over `rx`/`tx`. Every accepted command returns exactly one response byte.

---
 rtl/lr35902_dbg_pkg.sv | 44 ++++
 rtl/lr35902_dbg_uart_phy.sv | 122 ++++++++++++
 rtl/lr35902_dbg_ctl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/lr35902_dbg_pkg.sv
// rtl/lr35902_dbg_pkg.sv - shared constants and types for the LR35902 debug controller
package lr35902_dbg_pkg;
   localparam logic [3:0] OP_CTRL  = 4'h0;
   localparam logic [3:0] OP_ARG   = 4'h1;
   localparam logic [3:0] OP_SETBP = 4'h2;
   localparam logic [3:0] OP_CLRBP = 4'h3;
   localparam logic [3:0] OP_READ  = 4'h4;

   localparam logic [3:0] CTRL_HALT = 4'h0;
   localparam logic [3:0] CTRL_CONT = 4'h1;
   localparam logic [3:0] CTRL_STEP = 4'h2;

   localparam logic [3:0] RD_STATUS  = 4'h0;
   localparam logic [3:0] RD_FLAGS   = 4'h1;
   localparam logic [3:0] RD_PROBE   = 4'h2;
   localparam logic [3:0] RD_PC_LO   = 4'h3;
   localparam logic [3:0] RD_PC_HI   = 4'h4;
   localparam logic [3:0] RD_SP_LO   = 4'h5;
   localparam logic [3:0] RD_SP_HI   = 4'h6;
   localparam logic [3:0] RD_HIT_IDX = 4'h7;

   localparam int ST_HALT     = 0;
   localparam int ST_STEPPING = 1;
   localparam int ST_BP_HIT   = 2;
   localparam int ST_FERR     = 6;
   localparam int ST_OVR      = 7;

   localparam logic [7:0] RESP_ERR = 8'hEE;

   typedef enum logic [1:0] {CMD_IDLE, CMD_EXEC, CMD_WAIT_STEP, CMD_SEND} cmd_state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_WAIT_HIGH} rx_state_e;

   function automatic logic [7:0] status_byte(input logic ovr, input logic ferr, input logic bp_hit,
                                              input logic stepping, input logic halt);
      logic [7:0] s;
      s = 8'h00;
      s[ST_OVR]      = ovr;
      s[ST_FERR]     = ferr;
      s[ST_BP_HIT]   = bp_hit;
      s[ST_STEPPING] = stepping;
      s[ST_HALT]     = halt;
      return s;
   endfunction
endpackage

// File: rtl/lr35902_dbg_uart_phy.sv
// rtl/lr35902_dbg_uart_phy.sv - 8N1 UART receiver/transmitter with input synchronizer
module lr35902_dbg_uart_phy
   import lr35902_dbg_pkg::*;
#(
   parameter int BAUD_DIV = 12
) (
   input  logic       cpu_clk,
   input  logic       reset_n,
   input  logic       rx,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       rx_ferr,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       tx
);
   logic       rx_s1_q, rx_s2_q;
   rx_state_e  rx_st_q, rx_st_d;
   logic [7:0] rbcnt_q, rbcnt_d;
   logic [3:0] rbit_q, rbit_d;
   logic [7:0] rsh_q, rsh_d;
   logic       rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;

   logic       tx_q, tx_busy_q;
   logic [8:0] tsh_q;
   logic [3:0] tbit_q;
   logic [7:0] tbcnt_q;

   // Bit index 0 is the start bit, 1..8 data, 9 stop; samples land mid-bit.
   always_comb begin
      rx_st_d    = rx_st_q;
      rbcnt_d    = rbcnt_q;
      rbit_d     = rbit_q;
      rsh_d      = rsh_q;
      rx_valid_d = 1'b0;
      rx_ferr_d  = 1'b0;
      case (rx_st_q)
         RX_IDLE: if (!rx_s2_q) begin
            rx_st_d = RX_DATA;
            rbcnt_d = 8'(BAUD_DIV / 2 - 1);
            rbit_d  = 4'd0;
         end
         RX_DATA: if (rbcnt_q != 8'd0) begin
            rbcnt_d = rbcnt_q - 8'd1;
         end else begin
            rbcnt_d = 8'(BAUD_DIV - 1);
            rbit_d  = rbit_q + 4'd1;
            if (rbit_q == 4'd0) begin
               if (rx_s2_q) rx_st_d = RX_IDLE;
            end else if (rbit_q < 4'd9) begin
               rsh_d = {rx_s2_q, rsh_q[7:1]};
            end else if (rx_s2_q) begin
               rx_valid_d = 1'b1;
               rx_st_d    = RX_IDLE;
            end else begin
               rx_ferr_d = 1'b1;
               rx_st_d   = RX_WAIT_HIGH;
            end
         end
         RX_WAIT_HIGH: if (rx_s2_q) rx_st_d = RX_IDLE;
         default: rx_st_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge cpu_clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_st_q    <= RX_IDLE;
         rbcnt_q    <= 8'd0;
         rbit_q     <= 4'd0;
         rsh_q      <= 8'd0;
         rx_valid_q <= 1'b0;
         rx_ferr_q  <= 1'b0;
      end else begin
         rx_s1_q    <= rx;
         rx_s2_q    <= rx_s1_q;
         rx_st_q    <= rx_st_d;
         rbcnt_q    <= rbcnt_d;
         rbit_q     <= rbit_d;
         rsh_q      <= rsh_d;
         rx_valid_q <= rx_valid_d;
         rx_ferr_q  <= rx_ferr_d;
      end
   end

   // tsh_q holds data then stop; tbit_q counts the bits still to shift out.
   always_ff @(posedge cpu_clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_q      <= 1'b1;
         tx_busy_q <= 1'b0;
         tsh_q     <= 9'h1FF;
         tbit_q    <= 4'd0;
         tbcnt_q   <= 8'd0;
      end else if (!tx_busy_q) begin
         if (tx_start) begin
            tx_q      <= 1'b0;
            tsh_q     <= {1'b1, tx_data};
            tbit_q    <= 4'd9;
            tbcnt_q   <= 8'(BAUD_DIV - 1);
            tx_busy_q <= 1'b1;
         end
      end else if (tbcnt_q != 8'd0) begin
         tbcnt_q <= tbcnt_q - 8'd1;
      end else if (tbit_q == 4'd0) begin
         tx_busy_q <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         tx_q    <= tsh_q[0];
         tsh_q   <= {1'b1, tsh_q[8:1]};
         tbit_q  <= tbit_q - 4'd1;
         tbcnt_q <= 8'(BAUD_DIV - 1);
      end
   end

   assign rx_valid = rx_valid_q;
   assign rx_data  = rsh_q;
   assign rx_ferr  = rx_ferr_q;
   assign tx_busy  = tx_busy_q;
   assign tx       = tx_q;
endmodule

// File: rtl/lr35902_dbg_ctl.sv
// rtl/lr35902_dbg_ctl.sv - LR35902 debug controller: command FSM, breakpoints, single-step
module lr35902_dbg_ctl
   import lr35902_dbg_pkg::*;
#(
   parameter int NUM_BP   = 4,
   parameter int BAUD_DIV = 12
) (
   input  logic        cpu_clk,
   input  logic        reset_n,
   input  logic        fetch,
   input  logic [15:0] pc,
   input  logic [15:0] sp,
   input  logic [3:0]  f,
   input  logic [7:0]  probe,
   input  logic        rx,
   output logic        halt,
   output logic        tx,
   output logic        cts
);
   logic             rx_valid, rx_ferr, tx_start, tx_busy;
   logic [7:0]       rx_data, resp;
   cmd_state_e       st_q, st_d;
   logic [7:0]       cmd_q, cmd_d;
   logic             sent_q, sent_d, cts_q, cts_d, halt_q, halt_d;
   logic             stepping_q, stepping_d, skip_q, skip_d, bp_hit_q, bp_hit_d;
   logic             ovr_q, ovr_d, ferr_q, ferr_d;
   logic [15:0]      arg_q, arg_d, step_pc_q, step_pc_d;
   logic [15:0]      bp_q [NUM_BP];
   logic [15:0]      bp_d [NUM_BP];
   logic [NUM_BP-1:0] en_q, en_d;
   logic [2:0]       hit_idx_q, hit_idx_d, match_idx;
   logic             match, hit;
   logic [3:0]       opc, n;
   logic [7:0]       status;

   lr35902_dbg_uart_phy #(.BAUD_DIV(BAUD_DIV)) u_phy (
      .cpu_clk(cpu_clk), .reset_n(reset_n), .rx(rx),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ferr(rx_ferr),
      .tx_start(tx_start), .tx_data(resp), .tx_busy(tx_busy), .tx(tx)
   );

   assign opc    = cmd_q[7:4];
   assign n      = cmd_q[3:0];
   assign status = status_byte(ovr_q, ferr_q, bp_hit_q, stepping_q, halt_q);

   // Descending scan so the lowest matching index wins.
   always_comb begin
      match     = 1'b0;
      match_idx = 3'd0;
      for (int i = NUM_BP - 1; i >= 0; i--) begin
         if (en_q[i] && pc == bp_q[i]) begin
            match     = 1'b1;
            match_idx = 3'(i);
         end
      end
      hit = match && fetch && !stepping_q && !skip_q;
   end

   always_comb begin
      resp = status;
      if (opc == OP_READ) begin
         case (n)
            RD_STATUS:  resp = status;
            RD_FLAGS:   resp = {4'h0, f};
            RD_PROBE:   resp = probe;
            RD_PC_LO:   resp = pc[7:0];
            RD_PC_HI:   resp = pc[15:8];
            RD_SP_LO:   resp = sp[7:0];
            RD_SP_HI:   resp = sp[15:8];
            RD_HIT_IDX: resp = {5'b0, hit_idx_q};
            default:    resp = RESP_ERR;
         endcase
      end else if (!((opc == OP_CTRL && n <= CTRL_STEP) || opc == OP_ARG ||
                     opc == OP_SETBP || opc == OP_CLRBP)) begin
         resp = RESP_ERR;
      end
   end

   // Background events are applied first so a command in EXEC overrides a same-cycle hit.
   always_comb begin
      st_d       = st_q;
      cmd_d      = cmd_q;
      sent_d     = sent_q;
      cts_d      = cts_q;
      halt_d     = halt_q;
      stepping_d = stepping_q;
      skip_d     = skip_q;
      bp_hit_d   = bp_hit_q;
      ovr_d      = ovr_q;
      ferr_d     = ferr_q;
      arg_d      = arg_q;
      step_pc_d  = step_pc_q;
      bp_d       = bp_q;
      en_d       = en_q;
      hit_idx_d  = hit_idx_q;
      tx_start   = 1'b0;

      if (fetch && skip_q) skip_d = 1'b0;
      if (hit) begin
         halt_d    = 1'b1;
         bp_hit_d  = 1'b1;
         hit_idx_d = match_idx;
      end
      if (stepping_q && fetch && !halt_q && pc != step_pc_q) begin
         halt_d     = 1'b1;
         stepping_d = 1'b0;
      end

      case (st_q)
         CMD_IDLE: if (rx_valid) begin
            cmd_d = rx_data;
            cts_d = 1'b1;
            st_d  = CMD_EXEC;
         end
         CMD_EXEC: begin
            st_d = CMD_SEND;
            case (opc)
               OP_CTRL: case (n)
                  CTRL_HALT: begin
                     halt_d     = 1'b1;
                     stepping_d = 1'b0;
                  end
                  CTRL_CONT: begin
                     halt_d   = 1'b0;
                     skip_d   = 1'b1;
                     bp_hit_d = 1'b0;
                  end
                  CTRL_STEP: if (halt_q) begin
                     halt_d     = 1'b0;
                     stepping_d = 1'b1;
                     bp_hit_d   = 1'b0;
                     step_pc_d  = pc;
                     st_d       = CMD_WAIT_STEP;
                  end
                  default: ;
               endcase
               OP_ARG: arg_d = {arg_q[11:0], n};
               OP_SETBP: for (int i = 0; i < NUM_BP; i++) begin
                  if (n == 4'(i)) begin
                     bp_d[i] = arg_q;
                     en_d[i] = 1'b1;
                  end
               end
               OP_CLRBP: for (int i = 0; i < NUM_BP; i++) begin
                  if (n == 4'(i)) en_d[i] = 1'b0;
               end
               default: ;
            endcase
         end
         CMD_WAIT_STEP: begin
            if (!stepping_q) st_d = CMD_SEND;
            if (rx_valid && rx_data == 8'h00) begin
               halt_d     = 1'b1;
               stepping_d = 1'b0;
               cmd_d      = 8'h00;
               st_d       = CMD_SEND;
            end
         end
         CMD_SEND: if (!sent_q) begin
            tx_start = 1'b1;
            sent_d   = 1'b1;
            if (opc == OP_READ && n == RD_STATUS) begin
               ovr_d  = 1'b0;
               ferr_d = 1'b0;
            end
         end else if (!tx_busy) begin
            sent_d = 1'b0;
            cts_d  = 1'b0;
            st_d   = CMD_IDLE;
         end
         default: st_d = CMD_IDLE;
      endcase

      if (rx_valid && st_q != CMD_IDLE && !(st_q == CMD_WAIT_STEP && rx_data == 8'h00))
         ovr_d = 1'b1;
      if (rx_ferr) ferr_d = 1'b1;
   end

   always_ff @(posedge cpu_clk or negedge reset_n) begin
      if (!reset_n) begin
         st_q       <= CMD_IDLE;
         cmd_q      <= 8'h00;
         sent_q     <= 1'b0;
         cts_q      <= 1'b0;
         halt_q     <= 1'b0;
         stepping_q <= 1'b0;
         skip_q     <= 1'b0;
         bp_hit_q   <= 1'b0;
         ovr_q      <= 1'b0;
         ferr_q     <= 1'b0;
         arg_q      <= 16'h0000;
         step_pc_q  <= 16'h0000;
         en_q       <= '0;
         hit_idx_q  <= 3'd0;
         for (int i = 0; i < NUM_BP; i++) bp_q[i] <= 16'hFFFF;
      end else begin
         st_q       <= st_d;
         cmd_q      <= cmd_d;
         sent_q     <= sent_d;
         cts_q      <= cts_d;
         halt_q     <= halt_d;
         stepping_q <= stepping_d;
         skip_q     <= skip_d;
         bp_hit_q   <= bp_hit_d;
         ovr_q      <= ovr_d;
         ferr_q     <= ferr_d;
         arg_q      <= arg_d;
         step_pc_q  <= step_pc_d;
         en_q       <= en_d;
         hit_idx_q  <= hit_idx_d;
         bp_q       <= bp_d;
      end
   end

   assign halt = halt_q;
   assign cts  = cts_q;
endmodule
